nios_recv_addr: RTL

Avalon-MM slave input port: the receive-side counterpart to the Nios output PIO that drives an 8-bit address bus. An external producer in the same clock domain presents a byte on in_port with a one-cycle in_valid strobe. The block buffers bytes in a small FIFO for the Nios to read, reports FIFO status, and raises a maskable interrupt on data-available or overflow.

---
 rtl/nios_recv_addr.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nios_recv_addr.sv
// Avalon-MM receive port: buffers producer bytes in a small FIFO
// with status, sticky overflow and a maskable level interrupt.
module nios_recv_addr #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  in_valid,
  output logic                  irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            mask_q, mask_d;

  logic rd, wr, empty, full, pop, push, drop, clr;
  logic unused_wd;

  assign unused_wd = ^writedata[31:3];

  // Strobe decode and FIFO status flags.
  always_comb begin
    rd    = chipselect & ~read_n;
    wr    = chipselect & ~write_n;
    empty = (count_q == '0);
    full  = (count_q == CW'(FIFO_DEPTH));
    pop   = rd & (address == 2'd0) & ~empty;
    push  = in_valid & (~full | pop);
    drop  = in_valid & full & ~pop;
    clr   = wr & (address == 2'd1) & writedata[2];
  end

  // Next-state for FIFO storage, pointers, count and control regs.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mask_d  = mask_q;
    if (push) begin
      mem_d[wptr_q] = in_port;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A drop in the same cycle as a clear keeps overflow set.
    if (clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (wr && (address == 2'd2)) begin
      mask_d = writedata[1:0];
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mask_q  <= 2'b00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mask_q  <= mask_d;
    end
  end

  // FIFO entries need no reset; count gates their visibility.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  // Combinational register read mux, zero wait states.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        if (!empty) begin
          readdata[DATA_WIDTH-1:0] = mem_q[rptr_q];
        end
      end
      2'd1: begin
        readdata[0]      = empty;
        readdata[1]      = full;
        readdata[2]      = ovf_q;
        readdata[8+:CW]  = count_q;
      end
      2'd2: begin
        readdata[1:0] = mask_q;
      end
      default: readdata = '0;
    endcase
  end

  // Level interrupt straight from registered state.
  always_comb begin
    irq = (mask_q[0] & ~empty) | (mask_q[1] & ovf_q);
  end

endmodule
